// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

    // Controller states: normal arbitration, or walking the array to zero it.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Width of each per-requester grant counter (optional feature).
    localparam int GRANT_CNT_W = 16;

    // Number of entries in a register file with w address bits.
    function automatic int depth(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational R-way round-robin picker: the search starts just above ptr
// and wraps, so the most recently served requester has lowest priority.
module rr_arbiter #(
    parameter int R = 4,
    localparam int IW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    // First asserted request at or after ptr+1, modulo R.
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= R; k++) begin
            cand = (int'(ptr) + k) % R;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin sharing of a register file's single write port, plus a
// sequenced whole-array clear that writes zero to every address.
// Optional macro RF_ARB_GRANT_CNT_EN adds saturating per-requester grant
// counters on output grant_cnt.
module reg_file_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 2,
    parameter int R = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [R-1:0]     req_valid,
    input  logic [R*W-1:0]   req_addr,
    input  logic [R*N-1:0]   req_data,
    output logic [R-1:0]     req_ready,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic             rf_wr_en,
    output logic [W-1:0]     rf_w_addr,
    output logic [N-1:0]     rf_w_data
`ifdef RF_ARB_GRANT_CNT_EN
    ,
    output logic [R*GRANT_CNT_W-1:0] grant_cnt
`endif
);

    localparam int IW    = (R > 1) ? $clog2(R) : 1;
    localparam int DEPTH = depth(W);
    localparam logic [W-1:0] LAST_ADDR = W'(DEPTH - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   clr_cnt_q, clr_cnt_d;
    logic           rf_wr_en_q, rf_wr_en_d;
    logic [W-1:0]   rf_w_addr_q, rf_w_addr_d;
    logic [N-1:0]   rf_w_data_q, rf_w_data_d;
    logic           busy_q, busy_d;
    logic           clr_done_q, clr_done_d;

    logic [R-1:0]   arb_grant;
    logic [IW-1:0]  win_idx;
    logic           win_found;
    logic           grant_ok;
    logic           clear_start;

    rr_arbiter #(.R(R)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (win_idx),
        .found (win_found)
    );

    // Clear requests take priority over grants; nothing is granted while in
    // reset so a write can never be accepted and then dropped.
    assign clear_start = (state_q == IDLE) && clr_req;
    assign grant_ok    = clr_n && (state_q == IDLE) && !clr_req && win_found;
    assign req_ready   = grant_ok ? arb_grant : '0;

    // Next-state logic: grants register the winner's write; a clear presents
    // address 0 immediately and walks up to the last entry.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        clr_cnt_d   = clr_cnt_q;
        rf_wr_en_d  = 1'b0;
        rf_w_addr_d = rf_w_addr_q;
        rf_w_data_d = rf_w_data_q;
        busy_d      = 1'b0;
        clr_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
                    rf_wr_en_d  = 1'b1;
                    rf_w_addr_d = '0;
                    rf_w_data_d = '0;
                    busy_d      = 1'b1;
                end else if (grant_ok) begin
                    rr_ptr_d    = win_idx;
                    rf_wr_en_d  = 1'b1;
                    rf_w_addr_d = req_addr[int'(win_idx)*W +: W];
                    rf_w_data_d = req_data[int'(win_idx)*N +: N];
                end
            end
            CLEAR: begin
                // clr_cnt_q is the address currently being presented.
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d   = clr_cnt_q + 1'b1;
                    rf_wr_en_d  = 1'b1;
                    rf_w_addr_d = clr_cnt_q + 1'b1;
                    rf_w_data_d = '0;
                    busy_d      = 1'b1;
                    clr_done_d  = ((clr_cnt_q + 1'b1) == LAST_ADDR);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any clear in progress.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IW'(R - 1);
            clr_cnt_q   <= '0;
            rf_wr_en_q  <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            busy_q      <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            rf_wr_en_q  <= rf_wr_en_d;
            rf_w_addr_q <= rf_w_addr_d;
            rf_w_data_q <= rf_w_data_d;
            busy_q      <= busy_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign rf_wr_en  = rf_wr_en_q;
    assign rf_w_addr = rf_w_addr_q;
    assign rf_w_data = rf_w_data_q;
    assign busy      = busy_q;
    assign clr_done  = clr_done_q;

`ifdef RF_ARB_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] gcnt_q [R];
    logic [GRANT_CNT_W-1:0] gcnt_d [R];

    for (genvar gi = 0; gi < R; gi++) begin : g_gcnt
        // Saturating grant count, zeroed when a clear starts.
        always_comb begin
            gcnt_d[gi] = gcnt_q[gi];
            if (clear_start) begin
                gcnt_d[gi] = '0;
            end else if (req_ready[gi] && (gcnt_q[gi] != '1)) begin
                gcnt_d[gi] = gcnt_q[gi] + 1'b1;
            end
        end

        // Counter register.
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                gcnt_q[gi] <= '0;
            end else begin
                gcnt_q[gi] <= gcnt_d[gi];
            end
        end

        assign grant_cnt[gi*GRANT_CNT_W +: GRANT_CNT_W] = gcnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter: a reference model predicts grants
// and pushes the expected register-file outputs onto a scoreboard queue that
// is popped and compared one cycle later.
module tb_reg_file_wr_arbiter;

    localparam int N = 8;
    localparam int W = 2;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           clr_n = 1'b0;
    logic [R-1:0]   req_valid = '0;
    logic [R*W-1:0] req_addr = '0;
    logic [R*N-1:0] req_data = '0;
    logic [R-1:0]   req_ready;
    logic           clr_req = 1'b0;
    logic           busy;
    logic           clr_done;
    logic           rf_wr_en;
    logic [W-1:0]   rf_w_addr;
    logic [N-1:0]   rf_w_data;
`ifdef RF_ARB_GRANT_CNT_EN
    logic [R*16-1:0] grant_cnt;
`endif

    reg_file_wr_arbiter #(.N(N), .W(W), .R(R)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_done  (clr_done),
        .rf_wr_en  (rf_wr_en),
        .rf_w_addr (rf_w_addr),
        .rf_w_data (rf_w_data)
`ifdef RF_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr_en;
        logic [W-1:0] addr;
        logic [N-1:0] data;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_state = 0;      // 0 = idle, 1 = clearing
    int           m_ptr   = R - 1;
    int           m_cnt   = 0;
    int           m_win   = -1;
    logic [W-1:0] m_addr  = '0;
    logic [N-1:0] m_data  = '0;
    int           m_gcnt [R];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [R-1:0] v, input int p);
        for (int k = 1; k <= R; k++) begin
            int c;
            c = (p + k) % R;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic exp_t mk(input logic we, input logic [W-1:0] a, input logic [N-1:0] d,
                                input logic b, input logic dn);
        exp_t e;
        e.wr_en = we; e.addr = a; e.data = d; e.busy = b; e.done = dn;
        return e;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_state = 0; m_ptr = R - 1; m_cnt = 0; m_win = -1;
        m_addr = '0; m_data = '0;
        for (int i = 0; i < R; i++) m_gcnt[i] = 0;
        sb.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0));
    endtask

    // One clock cycle: entered at posedge+1 with inputs already driven.
    task automatic cycle();
        exp_t e;
        logic [R-1:0] exp_ready;
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("rf_wr_en", rf_wr_en, e.wr_en);
            check("rf_w_addr", rf_w_addr, e.addr);
            check("rf_w_data", rf_w_data, e.data);
            check("busy", busy, e.busy);
            check("clr_done", clr_done, e.done);
        end
`ifdef RF_ARB_GRANT_CNT_EN
        for (int i = 0; i < R; i++)
            check($sformatf("grant_cnt%0d", i), grant_cnt[i*16 +: 16], m_gcnt[i]);
`endif
        exp_ready = '0;
        m_win = -1;
        if (m_state == 0) begin
            if (clr_req) begin
                m_state = 1; m_cnt = 0; m_addr = '0; m_data = '0;
                for (int i = 0; i < R; i++) m_gcnt[i] = 0;
                sb.push_back(mk(1'b1, '0, '0, 1'b1, 1'b0));
            end else begin
                m_win = pick(req_valid, m_ptr);
                if (m_win >= 0) begin
                    exp_ready[m_win] = 1'b1;
                    m_ptr  = m_win;
                    m_addr = req_addr[m_win*W +: W];
                    m_data = req_data[m_win*N +: N];
                    if (m_gcnt[m_win] < 16'hFFFF) m_gcnt[m_win]++;
                    sb.push_back(mk(1'b1, m_addr, m_data, 1'b0, 1'b0));
                end else begin
                    sb.push_back(mk(1'b0, m_addr, m_data, 1'b0, 1'b0));
                end
            end
        end else begin
            if (m_cnt == (1 << W) - 1) begin
                m_state = 0;
                sb.push_back(mk(1'b0, m_addr, m_data, 1'b0, 1'b0));
            end else begin
                m_cnt++;
                m_addr = W'(m_cnt);
                sb.push_back(mk(1'b1, m_addr, '0, 1'b1, m_cnt == (1 << W) - 1));
            end
        end
        check("req_ready", req_ready, exp_ready);
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_wr_en", rf_wr_en, 1'b0);
        check("rst_rf_w_addr", rf_w_addr, 2'd0);
        check("rst_rf_w_data", rf_w_data, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        clr_n = 1'b1;

        // Single request from requester 0
        req_valid = 4'b0001;
        req_addr[0 +: W] = 2'd2;
        req_data[0 +: N] = 8'hA5;
        cycle();
        check("first_grant_is_req0", m_win, 0);
        req_valid = '0;
        cycle();

        // All requesters asserted: rotation, new data after each grant
        for (int i = 0; i < R; i++) begin
            req_addr[i*W +: W] = W'(i);
            req_data[i*N +: N] = N'(8'h10 + i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (m_win >= 0) req_data[m_win*N +: N] = N'($urandom_range(255));
        end

        // Two requesters only
        req_valid = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (m_win >= 0) req_addr[m_win*W +: W] = W'($urandom_range(3));
        end

        // Clear with requester 1 waiting; a second clr_req mid-clear is ignored
        req_valid = 4'b0010;
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cycle();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cycle();
        cycle();
        cycle();
        check("post_clear_grant_req1", m_win, 1);
        req_valid = '0;
        cycle();

        // Requester 2 granted three times, then a clear zeroes counters
        req_valid = 4'b0100;
        repeat (3) cycle();
        req_valid = '0;
        cycle();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (5) cycle();

        // Reset during the second clear write
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        req_valid = 4'b0010;
        cycle();
        #2;
        clr_n = 1'b0;
        #1;
        check("mid_rst_rf_wr_en", rf_wr_en, 1'b0);
        check("mid_rst_rf_w_addr", rf_w_addr, 2'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_clr_done", clr_done, 1'b0);
        check("mid_rst_req_ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        model_reset();
        req_valid = 4'b1111;
        cycle();
        check("post_rst_tie_req0", m_win, 0);
        req_valid = '0;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
